// File: rtl/pe_result_buffer.sv
// pe_result_buffer: two-entry result FIFO between the PE ALU stage and the
// downstream consumer. It can optionally sum groups of N = acc_len+1 beats and
// push only the group sum. That accumulate path exists only when the macro
// PE_RESBUF_ACC_EN is defined. In the default build acc_mode and acc_len are
// ignored and every accepted beat is pushed unchanged.
module pe_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             acc_mode,
  input  logic [3:0]       acc_len,
  output logic [1:0]       occupancy
);

  // Storage is indexed by 1-bit pointers, so only DEPTH == 2 is meaningful.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic             accept;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] push_data;

  // Modulo-2^WIDTH add; carry out of the top bit is dropped on purpose.
  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    wrap_add = a + b;
  endfunction

  // in_ready comes from the registered count only.
  // rst_n gates it so the block refuses beats while reset is held.
  assign in_ready  = rst_n && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign occupancy = count;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef PE_RESBUF_ACC_EN
  localparam logic ACC_IDLE = 1'b0;
  localparam logic ACC_RUN  = 1'b1;

  logic             acc_state;
  logic [3:0]       beat_cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;

  assign sum = wrap_add(acc, in_data);

  // Decide what gets pushed this cycle.
  // Pass-through pushes every beat; accumulate pushes only on a group's last beat.
  always_comb begin
    push      = 1'b0;
    push_data = in_data;
    if (!acc_mode) begin
      push = accept;
    end else if (accept) begin
      if (acc_state == ACC_IDLE) begin
        push = (acc_len == 4'd0);
      end else if (beat_cnt == acc_len) begin
        push      = 1'b1;
        push_data = sum;
      end
    end
  end

  // Group FSM: leaving accumulate mode drops any partially summed group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state <= ACC_IDLE;
      beat_cnt  <= 4'd0;
      acc       <= '0;
    end else if (!acc_mode) begin
      acc_state <= ACC_IDLE;
      beat_cnt  <= 4'd0;
    end else if (accept) begin
      if (acc_state == ACC_IDLE) begin
        acc <= in_data;
        if (acc_len != 4'd0) begin
          acc_state <= ACC_RUN;
          beat_cnt  <= 4'd1;
        end
      end else if (beat_cnt == acc_len) begin
        acc_state <= ACC_IDLE;
        beat_cnt  <= 4'd0;
      end else begin
        acc      <= sum;
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end
`else
  logic             unused_cfg;
  logic [WIDTH-1:0] unused_sum;

  assign unused_cfg = ^{acc_mode, acc_len};
  assign unused_sum = wrap_add(in_data, '0);

  // Without the accumulate path, every accepted beat goes straight into the FIFO.
  always_comb begin
    push      = accept;
    push_data = in_data;
  end
`endif

  // FIFO control: pointers and entry count.
  // A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: data only, so these registers have no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_pe_result_buffer.sv
// Directed bench for pe_result_buffer. Its expectations follow the build: the
// group-sum results apply when PE_RESBUF_ACC_EN is defined, and pass-through
// results apply otherwise.
module tb_pe_result_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        acc_mode;
  logic [3:0]  acc_len;
  logic [1:0]  occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  pe_result_buffer #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_mode  (acc_mode),
    .acc_len   (acc_len),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns before sampling or driving.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one cycle (in_ready is expected high).
  task automatic beat(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc_mode  = 1'b0;
    acc_len   = 4'd0;

    // Outputs while reset is held
    #2;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Pass-through with out_ready=1; the 0x22 and 0x33 edges also pop, so occupancy stays 1
    in_data = 32'h11; in_valid = 1'b1;
    chk("no_bypass", {31'd0, out_valid}, 32'd0);
    tick();
    chk("pt_v0", {31'd0, out_valid}, 32'd1);
    chk("pt_d0", out_data, 32'h11);
    in_data = 32'h22;
    tick();
    chk("pt_d1", out_data, 32'h22);
    chk("pushpop_occ1", {30'd0, occupancy}, 32'd1);
    in_data = 32'h33;
    tick();
    chk("pt_d2", out_data, 32'h33);
    chk("pushpop_occ2", {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("pt_empty_v", {31'd0, out_valid}, 32'd0);
    chk("pt_empty_d", out_data, 32'd0);

    // Backpressure: a full FIFO holds off 0xC, then drains in order
    out_ready = 1'b0;
    in_data = 32'hA; in_valid = 1'b1;
    tick();
    in_data = 32'hB;
    tick();
    chk("bp_occ2",     {30'd0, occupancy}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready},  32'd0);
    chk("bp_head",     out_data,           32'hA);
    in_data = 32'hC;
    tick();
    chk("bp_hold_occ",  {30'd0, occupancy}, 32'd2);
    chk("bp_hold_data", out_data,           32'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", out_data,           32'hB);
    chk("bp_occ1",  {30'd0, occupancy}, 32'd1);
    tick();
    chk("bp_out_c",   out_data,           32'hC);
    chk("bp_occ1b",   {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {30'd0, occupancy}, 32'd0);

    // Accumulate N=4: beats 1..4 give 10, beats 5..8 give 26
    acc_mode = 1'b1;
    acc_len  = 4'd3;
`ifdef PE_RESBUF_ACC_EN
    beat(32'd1); chk("acc_b1_v", {31'd0, out_valid}, 32'd0);
    beat(32'd2); chk("acc_b2_v", {31'd0, out_valid}, 32'd0);
    beat(32'd3); chk("acc_b3_v", {31'd0, out_valid}, 32'd0);
    beat(32'd4);
    chk("acc_sum10_v", {31'd0, out_valid}, 32'd1);
    chk("acc_sum10_d", out_data,           32'd10);
    beat(32'd5); chk("acc_b5_v", {31'd0, out_valid}, 32'd0);
    beat(32'd6);
    beat(32'd7);
    beat(32'd8);
    chk("acc_sum26_v", {31'd0, out_valid}, 32'd1);
    chk("acc_sum26_d", out_data,           32'd26);
`else
    beat(32'd1); chk("ign_b1", out_data, 32'd1);
    beat(32'd2); chk("ign_b2", out_data, 32'd2);
    beat(32'd3); chk("ign_b3", out_data, 32'd3);
    beat(32'd4); chk("ign_b4", out_data, 32'd4);
`endif
    tick();
    chk("acc_drain", {30'd0, occupancy}, 32'd0);

    // Wrap (N=2) and N=1
    acc_len = 4'd1;
`ifdef PE_RESBUF_ACC_EN
    beat(32'hFFFF_FFFF); chk("wrap_b1_v", {31'd0, out_valid}, 32'd0);
    beat(32'h2);         chk("wrap_sum",  out_data,           32'h1);
`else
    beat(32'hFFFF_FFFF); chk("ign_wrap1", out_data, 32'hFFFF_FFFF);
    beat(32'h2);         chk("ign_wrap2", out_data, 32'h2);
`endif
    acc_len = 4'd0;
    beat(32'h7);
    chk("n1_v", {31'd0, out_valid}, 32'd1);
    chk("n1_d", out_data,           32'h7);
    tick();

    // Leaving accumulate mode drops the partial group
    acc_len = 4'd3;
    beat(32'd50);
    beat(32'd50);
    tick();
    acc_mode = 1'b0;
    tick();
    acc_mode = 1'b1;
    beat(32'd1); beat(32'd1); beat(32'd1); beat(32'd1);
`ifdef PE_RESBUF_ACC_EN
    chk("modeclr_sum", out_data, 32'd4);
`else
    chk("modeclr_pt", out_data, 32'd1);
`endif
    tick();

    // Reset in the middle of a group, with an entry held back
    out_ready = 1'b0;
    beat(32'd9);
    beat(32'd9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_occ",      {30'd0, occupancy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready},  32'd0);
    chk("midrst_out_data", out_data,           32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("midrst_ready_after", {31'd0, in_ready}, 32'd1);
    beat(32'd1); beat(32'd1); beat(32'd1); beat(32'd1);
`ifdef PE_RESBUF_ACC_EN
    chk("midrst_sum_v", {31'd0, out_valid}, 32'd1);
    chk("midrst_sum_d", out_data,           32'd4);
`else
    chk("midrst_pt_d", out_data, 32'd1);
`endif
    tick();
    chk("final_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
